cas_dpram_be: RTL and testbench
===============================

# cas_dpram_be

Single-clock, true dual-port block RAM for the cassette overlay, parametrised in word width (whole bytes), depth, read-during-write policy and output latency. Adds per-byte write enables, read-valid strobes, a defined same-address collision policy, and a built-in clear engine that fills the array with a constant at reset or on request. It sits between the tape loader, which writes on port A, and the playback/overlay reader on port B.

## Interface
- DATA_BYTES, 1: word width is 8*DATA_BYTES bits (W).
- ADDR_W, 10: address width; depth is 2**ADDR_W words.
- RDW_MODE, 0: read-during-write result. 0 = new data, 1 = old data.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- CLEAR_BYTE, 8'h00: byte value replicated across the word by the clear engine.
- CLEAR_ON_RESET, 1: 1 = run the clear engine after reset.

- clock  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- clear_req  in  1  one-cycle request to start a clear.
- clear_busy  out  1  high while the clear engine owns the array.
- wren_a, rden_a  in  1  port A write / read strobe.
- byteena_a  in  DATA_BYTES  port A byte write enables.
- address_a  in  ADDR_W  port A address.
- data_a  in  W  port A write data.
- q_a  out  W  port A read data.
- qvalid_a  out  1  q_a is updated this cycle.
- wren_b, rden_b, byteena_b, address_b, data_b, q_b, qvalid_b: same as port A, for port B.

## Operation
- Memory storage: one lane per byte. A port writes byte i only when wren and byteena[i] are both high.
- Read: a read is accepted when rden is high and clear_busy is low. q changes only on an accepted read and otherwise holds its value. A write with no read leaves q unchanged.
- Read-during-write: this applies to reads on the same port and to reads from the other port, same address, same cycle.
  - RDW_MODE=0: the read returns the merged post-write word.
  - RDW_MODE=1: the read returns the pre-write word.
- Write collision (both ports write the same address): per byte, port A wins where byteena_a is set. Bytes enabled only by port B take data_b.
- Clear engine states:
  - IDLE → CLEAR on clear_req while in IDLE. Counter starts at 0.
  - CLEAR: writes {DATA_BYTES{CLEAR_BYTE}} to address cnt each cycle, then cnt+1.
  - CLEAR → IDLE after writing address 2**ADDR_W-1.
  - clear_req while in CLEAR is ignored: no restart, not queued.
- While clear_busy is high:
  - Port writes are dropped.
  - Reads are not accepted: qvalid stays 0 and q holds.
  - In-flight OUT_REG pipeline data still completes.
- Counter width is ADDR_W+1. cnt wrap is never used as the termination test.

## Timing
- Reset (reset_n low at an edge):
  - q_a, q_b, the pipeline registers and qvalid_* go to 0, and cnt goes to 0.
  - The state goes to CLEAR and clear_busy to 1 if CLEAR_ON_RESET, otherwise IDLE and 0.
  - Array contents are untouched during reset, and no clear writes occur while reset_n is low.
- Clear duration: the first clear write happens on the first edge with reset_n high (or the edge after clear_req is sampled). Exactly 2**ADDR_W writes follow on consecutive edges. clear_busy falls on the edge of the last write, so a port access is accepted in the very next cycle.
- Reset mid-clear: the engine restarts from 0 if CLEAR_ON_RESET, otherwise it aborts to IDLE. Partially cleared contents are left as-is.
- Read latency:
  - rden sampled at edge N gives q/qvalid at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
  - qvalid is high for exactly one cycle per accepted read.
  - Back-to-back reads give one result per cycle.
- Write: data is visible to a read accepted at the next edge, on either port, regardless of RDW_MODE.
- clear_req and a port write in the same cycle as IDLE→CLEAR: the port write is performed. Ports are blocked starting the following cycle.

## Test plan
- Reset clear, ADDR_W=4, CLEAR_BYTE=8'hA5, CLEAR_ON_RESET=1 → clear_busy high for exactly 16 cycles after reset release; reading all 16 addresses on port B returns 8'hA5.
- Byte enables, DATA_BYTES=2: write 16'h1234 to addr 3, then write data 16'hFFFF with byteena=2'b01 → read returns 16'h12FF one cycle after rden, qvalid pulses once; with OUT_REG=1 the result arrives two cycles after rden.
- Collision, DATA_BYTES=2: A writes 16'hAAAA with byteena 2'b10 and B writes 16'hBBBB with byteena 2'b11 to addr 5 in the same cycle → addr 5 reads 16'hAABB.
- Read-during-write on addr 7 (old 8'h11): A writes 8'h22 while B reads → q_b=8'h22 with RDW_MODE=0, q_b=8'h11 with RDW_MODE=1.
- Requested clear, ADDR_W=4: pulse clear_req, pulse it again 5 cycles later, issue a port-A write at cycle 8 → busy lasts exactly 16 cycles (no restart), the dropped write is absent, and all words equal CLEAR_BYTE.
- Reset asserted at clear cycle 9, CLEAR_ON_RESET=1 → after release busy lasts a full 16 cycles again, and qvalid_* stays 0 throughout.

Source files
------------

// File: rtl/cas_dpram_be.sv
// rtl/cas_dpram_be.sv - true dual-port byte-enabled RAM with clear engine for the cassette overlay
module cas_dpram_be #(
    parameter int          DATA_BYTES     = 1,
    parameter int          ADDR_W         = 10,
    parameter int          RDW_MODE       = 0,
    parameter int          OUT_REG        = 0,
    parameter logic [7:0]  CLEAR_BYTE     = 8'h00,
    parameter int          CLEAR_ON_RESET = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear_req,
    output logic                    clear_busy,
    input  logic                    wren_a,
    input  logic                    rden_a,
    input  logic [DATA_BYTES-1:0]   byteena_a,
    input  logic [ADDR_W-1:0]       address_a,
    input  logic [8*DATA_BYTES-1:0] data_a,
    output logic [8*DATA_BYTES-1:0] q_a,
    output logic                    qvalid_a,
    input  logic                    wren_b,
    input  logic                    rden_b,
    input  logic [DATA_BYTES-1:0]   byteena_b,
    input  logic [ADDR_W-1:0]       address_b,
    input  logic [8*DATA_BYTES-1:0] data_b,
    output logic [8*DATA_BYTES-1:0] q_b,
    output logic                    qvalid_b
);

    localparam int              W          = 8 * DATA_BYTES;
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT   = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [W-1:0]    CLEAR_WORD = {DATA_BYTES{CLEAR_BYTE}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Extra bit so the address sweep never relies on wrap-around to stop.
    logic [ADDR_W:0] cnt;
    logic            busy;

    logic [W-1:0] mem [DEPTH];

    // Effective write port A: the clear engine borrows it while busy.
    logic [DATA_BYTES-1:0] lane_we_a;
    logic [DATA_BYTES-1:0] lane_we_b;
    logic [ADDR_W-1:0]     wr_addr_a;
    logic [W-1:0]          wr_data_a;

    logic         rd_acc_a;
    logic         rd_acc_b;
    logic [W-1:0] old_a;
    logic [W-1:0] old_b;
    logic [W-1:0] new_a;
    logic [W-1:0] new_b;
    logic [W-1:0] rd_word_a;
    logic [W-1:0] rd_word_b;

    // Clear-engine state register; reset either starts or aborts a sweep.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Clear-engine next state; requests during a sweep are dropped.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (clear_req) state_next = ST_CLEAR;
            ST_CLEAR: if (cnt == LAST_CNT) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Clear-engine outputs.
    always_comb begin
        busy = (state == ST_CLEAR);
    end

    assign clear_busy = busy;

    // Sweep counter: parked at zero while idle so every sweep starts at address 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + (ADDR_W + 1)'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Write-lane selection; port A owns any byte both ports try to write at one address.
    always_comb begin
        lane_we_a = '0;
        lane_we_b = '0;
        wr_addr_a = address_a;
        wr_data_a = data_a;
        if (reset_n) begin
            if (busy) begin
                wr_addr_a = cnt[ADDR_W-1:0];
                wr_data_a = CLEAR_WORD;
                lane_we_a = '1;
            end else begin
                lane_we_a = wren_a ? byteena_a : '0;
                lane_we_b = (wren_b ? byteena_b : '0)
                          & ~((address_a == address_b) ? lane_we_a : '0);
            end
        end
    end

    // Byte-lane array writes; contents are never reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (lane_we_a[i]) mem[wr_addr_a][i*8 +: 8] <= wr_data_a[i*8 +: 8];
            if (lane_we_b[i]) mem[address_b][i*8 +: 8] <= data_b[i*8 +: 8];
        end
    end

    // Read path: pre-write word, merged post-write word, and the RDW choice between them.
    always_comb begin
        rd_acc_a = rden_a & ~busy;
        rd_acc_b = rden_b & ~busy;
        old_a    = mem[address_a];
        old_b    = mem[address_b];
        new_a    = old_a;
        new_b    = old_b;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (lane_we_a[i] && (wr_addr_a == address_a)) begin
                new_a[i*8 +: 8] = wr_data_a[i*8 +: 8];
            end else if (lane_we_b[i] && (address_b == address_a)) begin
                new_a[i*8 +: 8] = data_b[i*8 +: 8];
            end
            if (lane_we_a[i] && (wr_addr_a == address_b)) begin
                new_b[i*8 +: 8] = wr_data_a[i*8 +: 8];
            end else if (lane_we_b[i]) begin
                new_b[i*8 +: 8] = data_b[i*8 +: 8];
            end
        end
        rd_word_a = (RDW_MODE != 0) ? old_a : new_a;
        rd_word_b = (RDW_MODE != 0) ? old_b : new_b;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [W-1:0] pipe_a;
            logic [W-1:0] pipe_b;
            logic         pipe_v_a;
            logic         pipe_v_b;

            // Two-stage read pipeline; an in-flight word completes even if a clear starts.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    pipe_a   <= '0;
                    pipe_b   <= '0;
                    pipe_v_a <= 1'b0;
                    pipe_v_b <= 1'b0;
                    q_a      <= '0;
                    q_b      <= '0;
                    qvalid_a <= 1'b0;
                    qvalid_b <= 1'b0;
                end else begin
                    pipe_v_a <= rd_acc_a;
                    pipe_v_b <= rd_acc_b;
                    if (rd_acc_a) pipe_a <= rd_word_a;
                    if (rd_acc_b) pipe_b <= rd_word_b;
                    qvalid_a <= pipe_v_a;
                    qvalid_b <= pipe_v_b;
                    if (pipe_v_a) q_a <= pipe_a;
                    if (pipe_v_b) q_b <= pipe_b;
                end
            end
        end else begin : g_no_out_reg
            // Single-stage read register; q holds between accepted reads.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    q_a      <= '0;
                    q_b      <= '0;
                    qvalid_a <= 1'b0;
                    qvalid_b <= 1'b0;
                end else begin
                    qvalid_a <= rd_acc_a;
                    qvalid_b <= rd_acc_b;
                    if (rd_acc_a) q_a <= rd_word_a;
                    if (rd_acc_b) q_b <= rd_word_b;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_cas_dpram_be.sv
// tb/tb_cas_dpram_be.sv - self-checking bench for cas_dpram_be
module tb_cas_dpram_be;

    logic        clock;
    logic        reset_n;
    logic        clear_req;
    logic        wren_a, rden_a, wren_b, rden_b;
    logic [1:0]  byteena_a, byteena_b;
    logic [3:0]  address_a, address_b;
    logic [15:0] data_a, data_b;

    logic [15:0] q_a0, q_b0, q_a1, q_b1;
    logic        qvalid_a0, qvalid_b0, qvalid_a1, qvalid_b1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sq0[$];
    exp_t sq1[$];
    exp_t sq2[$];
    exp_t sq3[$];

    typedef struct {
        logic        we_a;
        logic [1:0]  be_a;
        logic [3:0]  ad_a;
        logic [15:0] d_a;
        logic        rd_a;
        logic        we_b;
        logic [1:0]  be_b;
        logic [3:0]  ad_b;
        logic [15:0] d_b;
        logic        rd_b;
        logic [15:0] qa_new;
        logic [15:0] qa_old;
        logic [15:0] qb_new;
        logic [15:0] qb_old;
    } vec_t;

    vec_t vt[13];

    cas_dpram_be #(
        .DATA_BYTES(2), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0),
        .CLEAR_BYTE(8'hA5), .CLEAR_ON_RESET(1)
    ) u_new (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy0),
        .wren_a(wren_a), .rden_a(rden_a), .byteena_a(byteena_a), .address_a(address_a),
        .data_a(data_a), .q_a(q_a0), .qvalid_a(qvalid_a0),
        .wren_b(wren_b), .rden_b(rden_b), .byteena_b(byteena_b), .address_b(address_b),
        .data_b(data_b), .q_b(q_b0), .qvalid_b(qvalid_b0)
    );

    cas_dpram_be #(
        .DATA_BYTES(2), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1),
        .CLEAR_BYTE(8'hA5), .CLEAR_ON_RESET(1)
    ) u_old (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy1),
        .wren_a(wren_a), .rden_a(rden_a), .byteena_a(byteena_a), .address_a(address_a),
        .data_a(data_a), .q_a(q_a1), .qvalid_a(qvalid_a1),
        .wren_b(wren_b), .rden_b(rden_b), .byteena_b(byteena_b), .address_b(address_b),
        .data_b(data_b), .q_b(q_b1), .qvalid_b(qvalid_b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0:       return sq0.size();
            1:       return sq1.size();
            2:       return sq2.size();
            default: return sq3.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int ch);
        case (ch)
            0:       return sq0.pop_front();
            1:       return sq1.pop_front();
            2:       return sq2.pop_front();
            default: return sq3.pop_front();
        endcase
    endfunction

    function automatic int qhead_due(input int ch);
        case (ch)
            0:       return sq0[0].due;
            1:       return sq1[0].due;
            2:       return sq2[0].due;
            default: return sq3[0].due;
        endcase
    endfunction

    task automatic sb_check(input int ch, input logic v, input logic [15:0] q);
        exp_t e;
        if (v !== 1'b0) begin
            checks++;
            if (qsize(ch) == 0) begin
                errors++;
                $display("FAIL unexpected_qvalid ch%0d qvalid=%b q=%h required qvalid 0", ch, v, q);
            end else begin
                e = qpop(ch);
                if (q !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL read ch%0d got %h at cycle %0d required %h at cycle %0d",
                             ch, q, cyc, e.data, e.due);
                end
            end
        end else if (qsize(ch) > 0 && qhead_due(ch) <= cyc) begin
            checks++;
            errors++;
            e = qpop(ch);
            $display("FAIL missing_qvalid ch%0d qvalid=0 at cycle %0d required %h at cycle %0d",
                     ch, cyc, e.data, e.due);
        end
    endtask

    // ch 0/1: u_new port A/B (latency 1, new data); ch 2/3: u_old port A/B (latency 2, old data)
    task automatic push(input int port, input logic [15:0] vnew, input logic [15:0] vold);
        exp_t e;
        e.data = vnew;
        e.due  = cyc + 1;
        if (port == 0) sq0.push_back(e); else sq1.push_back(e);
        e.data = vold;
        e.due  = cyc + 2;
        if (port == 0) sq2.push_back(e); else sq3.push_back(e);
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
        sb_check(0, qvalid_a0, q_a0);
        sb_check(1, qvalid_b0, q_b0);
        sb_check(2, qvalid_a1, q_a1);
        sb_check(3, qvalid_b1, q_b1);
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0;
        wren_a = 1'b0; rden_a = 1'b0; byteena_a = 2'b00; address_a = 4'd0; data_a = 16'h0;
        wren_b = 1'b0; rden_b = 1'b0; byteena_b = 2'b00; address_b = 4'd0; data_b = 16'h0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qsize(0) + qsize(1) + qsize(2) + qsize(3)) > 0 && n < 8) begin
            tick();
            n++;
        end
    endtask

    task automatic read_all(input logic [15:0] expv);
        for (int a = 0; a < 16; a++) begin
            rden_b = 1'b1; address_b = 4'(a);
            rden_a = 1'b1; address_a = 4'(15 - a);
            push(0, expv, expv);
            push(1, expv, expv);
            tick();
        end
        idle_inputs();
        drain();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_q_a_new"}, q_a0, 16'h0);
        chk({tag, "_q_b_new"}, q_b0, 16'h0);
        chk({tag, "_q_a_old"}, q_a1, 16'h0);
        chk({tag, "_q_b_old"}, q_b1, 16'h0);
        chk({tag, "_qvalid"}, {12'h0, qvalid_a0, qvalid_b0, qvalid_a1, qvalid_b1}, 16'h0);
        chk({tag, "_busy"}, {14'h0, busy0, busy1}, 16'h3);
    endtask

    // Counts cycles with reset_n high and clear_busy high, starting at the current negedge.
    task automatic count_busy(input string tag, input logic reads_on);
        int c0 = 0;
        int c1 = 0;
        int n  = 0;
        logic qv = 1'b0;
        while ((busy0 || busy1) && n < 100) begin
            if (busy0) c0++;
            if (busy1) c1++;
            n++;
            qv = qv | qvalid_a0 | qvalid_b0 | qvalid_a1 | qvalid_b1;
            rden_a = reads_on; rden_b = reads_on;
            tick();
        end
        idle_inputs();
        chk({tag, "_busy_cycles_new"}, 16'(c0), 16'd16);
        chk({tag, "_busy_cycles_old"}, 16'(c1), 16'd16);
        if (reads_on) chk({tag, "_qvalid_while_busy"}, {15'h0, qv}, 16'h0);
    endtask

    initial begin
        // {we_a,be_a,ad_a,d_a,rd_a, we_b,be_b,ad_b,d_b,rd_b, qa_new,qa_old, qb_new,qb_old}
        vt[0]  = '{1'b1, 2'b11, 4'd3, 16'h1234, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0};
        vt[1]  = '{1'b1, 2'b01, 4'd3, 16'hFFFF, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0};
        vt[2]  = '{1'b0, 2'b00, 4'd3, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b1, 16'h12FF, 16'h12FF, 16'h12FF, 16'h12FF};
        vt[3]  = '{1'b1, 2'b10, 4'd5, 16'hAAAA, 1'b0, 1'b1, 2'b11, 4'd5, 16'hBBBB, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0};
        vt[4]  = '{1'b0, 2'b00, 4'd5, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b1, 16'hAABB, 16'hAABB, 16'hAABB, 16'hAABB};
        vt[5]  = '{1'b1, 2'b11, 4'd7, 16'h1111, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0};
        vt[6]  = '{1'b1, 2'b11, 4'd7, 16'h2222, 1'b1, 1'b0, 2'b00, 4'd7, 16'h0000, 1'b1, 16'h2222, 16'h1111, 16'h2222, 16'h1111};
        vt[7]  = '{1'b0, 2'b00, 4'd7, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd7, 16'h0000, 1'b1, 16'h2222, 16'h2222, 16'h2222, 16'h2222};
        vt[8]  = '{1'b1, 2'b01, 4'd9, 16'h00CC, 1'b1, 1'b1, 2'b11, 4'd9, 16'h3344, 1'b1, 16'h33CC, 16'hA5A5, 16'h33CC, 16'hA5A5};
        vt[9]  = '{1'b0, 2'b00, 4'd9, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd9, 16'h0000, 1'b1, 16'h33CC, 16'h33CC, 16'h33CC, 16'h33CC};
        vt[10] = '{1'b0, 2'b00, 4'd3, 16'h0000, 1'b1, 1'b1, 2'b10, 4'd3, 16'h5566, 1'b0, 16'h55FF, 16'h12FF, 16'h0, 16'h0};
        vt[11] = '{1'b0, 2'b00, 4'd3, 16'h0000, 1'b1, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 16'h55FF, 16'h55FF, 16'hA5A5, 16'hA5A5};
        vt[12] = '{1'b1, 2'b11, 4'd0, 16'h0000, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0};

        idle_inputs();
        reset_n = 1'b0;
        tick(); tick(); tick();
        reset_checks("reset");

        // Clear after reset release, then every word must hold the clear pattern.
        reset_n = 1'b1;
        count_busy("reset_clear", 1'b0);
        read_all(16'hA5A5);

        // Byte enables, collisions, read-during-write and back-to-back reads.
        for (int i = 0; i < 13; i++) begin
            wren_a = vt[i].we_a; byteena_a = vt[i].be_a; address_a = vt[i].ad_a;
            data_a = vt[i].d_a;  rden_a = vt[i].rd_a;
            wren_b = vt[i].we_b; byteena_b = vt[i].be_b; address_b = vt[i].ad_b;
            data_b = vt[i].d_b;  rden_b = vt[i].rd_b;
            if (vt[i].rd_a) push(0, vt[i].qa_new, vt[i].qa_old);
            if (vt[i].rd_b) push(1, vt[i].qb_new, vt[i].qb_old);
            tick();
        end
        idle_inputs();
        drain();
        chk("hold_q_a_new", q_a0, 16'h55FF);
        chk("hold_q_b_new", q_b0, 16'hA5A5);
        chk("hold_q_a_old", q_a1, 16'h55FF);
        chk("hold_q_b_old", q_b1, 16'hA5A5);

        // Requested clear with an ignored second request and a dropped write.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        begin
            int c0 = 0;
            int c1 = 0;
            int n  = 0;
            while ((busy0 || busy1) && n < 100) begin
                if (busy0) c0++;
                if (busy1) c1++;
                n++;
                clear_req = (n == 5);
                wren_a = (n == 8); byteena_a = 2'b11; address_a = 4'd2; data_a = 16'h7777;
                rden_b = (n == 8); address_b = 4'd2;
                tick();
            end
            idle_inputs();
            chk("req_clear_busy_cycles_new", 16'(c0), 16'd16);
            chk("req_clear_busy_cycles_old", 16'(c1), 16'd16);
        end
        read_all(16'hA5A5);

        // Reset in the middle of a sweep restarts it in full; reads stay blocked throughout.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        rden_a = 1'b1; rden_b = 1'b1; address_a = 4'd3; address_b = 4'd5;
        for (int k = 0; k < 9; k++) tick();
        reset_n = 1'b0;
        tick(); tick();
        reset_checks("mid_reset");
        reset_n = 1'b1;
        count_busy("mid_reset_clear", 1'b1);
        read_all(16'hA5A5);

        chk("scoreboard_empty", 16'(qsize(0) + qsize(1) + qsize(2) + qsize(3)), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
